// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: write, step and dual read-port signals.
interface reg_bank_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [WIDTH-1:0]  wr_mask;
  logic              step_en;
  logic [ADDR_W-1:0] step_addr;
  logic              step_dir;
  logic              step_wrap;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a;
  logic [WIDTH-1:0]  rd_data_b;
  logic              zero_a;
  logic              neg_a;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask,
    output step_en, step_addr, step_dir,
    output rd_addr_a, rd_addr_b,
    input  step_wrap, rd_data_a, rd_data_b, zero_a, neg_a
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask,
    input  step_en, step_addr, step_dir,
    input  rd_addr_a, rd_addr_b,
    output step_wrap, rd_data_a, rd_data_b, zero_a, neg_a
  );
endinterface

// File: rtl/reg_bank.sv
// Small register bank with masked write, +/-1 step with wrap flag,
// two combinational read ports and optional write-to-read forwarding.
module reg_bank #(
  parameter int               WIDTH       = 8,
  parameter int               NUM_REGS    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               BYPASS      = 1'b1
) (
  input logic       clk,
  input logic       reset,
  reg_bank_if.slave bus
);
  localparam int              ADDR_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W:0] LIMIT  = (ADDR_W + 1)'(NUM_REGS);

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic             wr_hit;
  logic             step_hit;
  logic             step_wraps;
  logic [WIDTH-1:0] wr_cur;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] step_cur;
  logic [WIDTH-1:0] step_next;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] out_a;

  // Decoded lookups; addresses past NUM_REGS match nothing and read as zero.
  always_comb begin
    wr_cur   = '0;
    step_cur = '0;
    rd_a     = '0;
    rd_b     = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.wr_addr   == ADDR_W'(i)) wr_cur   = regs[i];
      if (bus.step_addr == ADDR_W'(i)) step_cur = regs[i];
      if (bus.rd_addr_a == ADDR_W'(i)) rd_a     = regs[i];
      if (bus.rd_addr_b == ADDR_W'(i)) rd_b     = regs[i];
    end
  end

  // A write to the same register as a step wins; the step is dropped.
  assign wr_hit   = bus.wr_en && ({1'b0, bus.wr_addr} < LIMIT);
  assign step_hit = bus.step_en && ({1'b0, bus.step_addr} < LIMIT) &&
                    !(wr_hit && (bus.wr_addr == bus.step_addr));

  assign wr_merged  = (wr_cur & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
  assign step_next  = bus.step_dir ? (step_cur - 1'b1) : (step_cur + 1'b1);
  assign step_wraps = bus.step_dir ? (step_cur == '0) : (step_cur == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
      bus.step_wrap <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_hit && (bus.wr_addr == ADDR_W'(i)))
          regs[i] <= wr_merged;
        else if (step_hit && (bus.step_addr == ADDR_W'(i)))
          regs[i] <= step_next;
      end
      bus.step_wrap <= step_hit && step_wraps;
    end
  end

  // Only writes are forwarded; step results appear after the edge.
  always_comb begin
    out_a = rd_a;
    if (BYPASS && wr_hit && (bus.wr_addr == bus.rd_addr_a)) out_a = wr_merged;
    bus.rd_data_b = rd_b;
    if (BYPASS && wr_hit && (bus.wr_addr == bus.rd_addr_b)) bus.rd_data_b = wr_merged;
  end

  assign bus.rd_data_a = out_a;
  assign bus.zero_a    = (out_a == '0);
  assign bus.neg_a     = out_a[WIDTH-1];
endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: three instances cover
// BYPASS=1, BYPASS=0 with non-zero reset value, and NUM_REGS=3.
module tb_reg_bank;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  reg_bank_if #(.WIDTH(8), .ADDR_W(2)) bus0 ();
  reg_bank_if #(.WIDTH(8), .ADDR_W(2)) bus1 ();
  reg_bank_if #(.WIDTH(8), .ADDR_W(2)) bus2 ();

  reg_bank #(.WIDTH(8), .NUM_REGS(4), .RESET_VALUE(8'h00), .BYPASS(1'b1))
    u_byp (.clk(clk), .reset(reset), .bus(bus0));
  reg_bank #(.WIDTH(8), .NUM_REGS(4), .RESET_VALUE(8'h5A), .BYPASS(1'b0))
    u_nobyp (.clk(clk), .reset(reset), .bus(bus1));
  reg_bank #(.WIDTH(8), .NUM_REGS(3), .RESET_VALUE(8'h00), .BYPASS(1'b1))
    u_three (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 1 time unit later.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus0.wr_en = 0; bus0.wr_addr = 0; bus0.wr_data = 0; bus0.wr_mask = 0;
    bus0.step_en = 0; bus0.step_addr = 0; bus0.step_dir = 0;
    bus0.rd_addr_a = 0; bus0.rd_addr_b = 0;
    bus1.wr_en = 0; bus1.wr_addr = 0; bus1.wr_data = 0; bus1.wr_mask = 0;
    bus1.step_en = 0; bus1.step_addr = 0; bus1.step_dir = 0;
    bus1.rd_addr_a = 0; bus1.rd_addr_b = 0;
    bus2.wr_en = 0; bus2.wr_addr = 0; bus2.wr_data = 0; bus2.wr_mask = 0;
    bus2.step_en = 0; bus2.step_addr = 0; bus2.step_dir = 0;
    bus2.rd_addr_a = 0; bus2.rd_addr_b = 0;

    tick(); tick(); #1;
    chk("rst_r0", bus0.rd_data_a, 8'h00);
    chk("rst_zero", bus0.zero_a, 1'b1);
    chk("rst_wrap", bus0.step_wrap, 1'b0);
    chk("rst_value", bus1.rd_data_a, 8'h5A);
    tick();
    reset = 1'b0;

    // Full write then nibble-masked write on r2
    bus0.wr_en = 1; bus0.wr_addr = 2; bus0.wr_data = 8'hA5; bus0.wr_mask = 8'hFF;
    bus0.rd_addr_a = 2;
    #1 chk("byp_full", bus0.rd_data_a, 8'hA5);
    tick();
    bus0.wr_data = 8'h3C; bus0.wr_mask = 8'h0F;
    #1 chk("byp_merge", bus0.rd_data_a, 8'hAC);
    tick();
    bus0.wr_en = 0;
    #1 chk("mask_r2", bus0.rd_data_a, 8'hAC);
    chk("mask_zero_a", bus0.zero_a, 1'b0);
    chk("mask_neg_a", bus0.neg_a, 1'b1);
    bus0.wr_en = 1; bus0.wr_data = 8'hFF; bus0.wr_mask = 8'h00;
    tick();
    bus0.wr_en = 0;
    #1 chk("mask_none", bus0.rd_data_a, 8'hAC);

    // r1 = r3 = 0xFF, then wrap r1 both ways
    bus0.wr_en = 1; bus0.wr_addr = 1; bus0.wr_data = 8'hFF; bus0.wr_mask = 8'hFF;
    tick();
    bus0.wr_addr = 3;
    tick();
    bus0.wr_en = 0;
    bus0.step_en = 1; bus0.step_addr = 1; bus0.step_dir = 0; bus0.rd_addr_b = 1;
    #1 chk("no_step_fwd", bus0.rd_data_b, 8'hFF);
    tick();
    bus0.step_en = 0; bus0.rd_addr_a = 1;
    #1 chk("inc_wrap_val", bus0.rd_data_a, 8'h00);
    chk("inc_wrap_zero", bus0.zero_a, 1'b1);
    chk("inc_wrap_flag", bus0.step_wrap, 1'b1);
    tick();
    #1 chk("wrap_one_cycle", bus0.step_wrap, 1'b0);
    bus0.step_en = 1; bus0.step_addr = 1; bus0.step_dir = 1;
    tick();
    bus0.step_en = 0;
    #1 chk("dec_wrap_val", bus0.rd_data_a, 8'hFF);
    chk("dec_wrap_flag", bus0.step_wrap, 1'b1);
    chk("dec_wrap_neg", bus0.neg_a, 1'b1);
    bus0.step_en = 1; bus0.step_addr = 2; bus0.step_dir = 0; bus0.rd_addr_b = 2;
    tick();
    bus0.step_en = 0;
    #1 chk("inc_plain_val", bus0.rd_data_b, 8'hAD);
    chk("inc_plain_flag", bus0.step_wrap, 1'b0);

    // Write and step on same register: write only, wrap suppressed
    bus0.wr_en = 1; bus0.wr_addr = 3; bus0.wr_data = 8'h10; bus0.wr_mask = 8'hFF;
    bus0.step_en = 1; bus0.step_addr = 3; bus0.step_dir = 0;
    tick();
    bus0.wr_en = 0; bus0.step_en = 0; bus0.rd_addr_a = 3;
    #1 chk("conflict_val", bus0.rd_data_a, 8'h10);
    chk("conflict_wrap", bus0.step_wrap, 1'b0);

    // Write and step on different registers in one cycle
    bus0.wr_en = 1; bus0.wr_addr = 0; bus0.wr_data = 8'h77; bus0.wr_mask = 8'hFF;
    bus0.step_en = 1; bus0.step_addr = 3; bus0.step_dir = 1;
    tick();
    bus0.wr_en = 0; bus0.step_en = 0; bus0.rd_addr_a = 0; bus0.rd_addr_b = 3;
    #1 chk("dual_wr", bus0.rd_data_a, 8'h77);
    chk("dual_step", bus0.rd_data_b, 8'h0F);
    bus0.rd_addr_b = 0;
    #1 chk("same_sel_b", bus0.rd_data_b, 8'h77);

    // Forwarding versus no forwarding
    bus0.wr_en = 1; bus0.wr_addr = 0; bus0.wr_data = 8'h55; bus0.wr_mask = 8'hFF;
    bus1.wr_en = 1; bus1.wr_addr = 0; bus1.wr_data = 8'h55; bus1.wr_mask = 8'hFF;
    bus1.rd_addr_a = 0;
    #1 chk("fwd_same_cycle", bus0.rd_data_a, 8'h55);
    chk("nofwd_same_cycle", bus1.rd_data_a, 8'h5A);
    tick();
    bus0.wr_en = 0; bus1.wr_en = 0;
    #1 chk("fwd_next", bus0.rd_data_a, 8'h55);
    chk("nofwd_next", bus1.rd_data_a, 8'h55);
    bus1.step_en = 1; bus1.step_addr = 1; bus1.step_dir = 1; bus1.rd_addr_b = 1;
    #1 chk("nofwd_step_now", bus1.rd_data_b, 8'h5A);
    tick();
    bus1.step_en = 0;
    #1 chk("nofwd_step_next", bus1.rd_data_b, 8'h59);

    // NUM_REGS=3: address 3 is out of range
    bus2.wr_en = 1; bus2.wr_addr = 2; bus2.wr_data = 8'h81; bus2.wr_mask = 8'hFF;
    tick();
    bus2.wr_addr = 3; bus2.wr_data = 8'hFF;
    bus2.step_en = 1; bus2.step_addr = 3; bus2.step_dir = 1;
    bus2.rd_addr_a = 2; bus2.rd_addr_b = 3;
    #1 chk("oob_rd_fwd", bus2.rd_data_b, 8'h00);
    chk("oob_r2_now", bus2.rd_data_a, 8'h81);
    tick();
    bus2.wr_en = 0; bus2.step_en = 0;
    #1 chk("oob_wrap", bus2.step_wrap, 1'b0);
    chk("oob_rd", bus2.rd_data_b, 8'h00);
    chk("oob_r2", bus2.rd_data_a, 8'h81);
    bus2.rd_addr_a = 0;
    #1 chk("oob_r0", bus2.rd_data_a, 8'h00);
    bus2.rd_addr_a = 1;
    #1 chk("oob_r1", bus2.rd_data_a, 8'h00);

    // Reset beats simultaneous write and step; forwarding stays live meanwhile
    reset = 1'b1;
    bus0.wr_en = 1; bus0.wr_addr = 1; bus0.wr_data = 8'h33; bus0.wr_mask = 8'hFF;
    bus0.step_en = 1; bus0.step_addr = 0; bus0.step_dir = 0;
    bus0.rd_addr_a = 1; bus0.rd_addr_b = 0;
    #1 chk("rst_fwd", bus0.rd_data_a, 8'h33);
    tick();
    reset = 1'b0;
    bus0.wr_en = 0; bus0.step_en = 0;
    #1 chk("rst_req_wr", bus0.rd_data_a, 8'h00);
    chk("rst_req_step", bus0.rd_data_b, 8'h00);
    chk("rst_req_wrap", bus0.step_wrap, 1'b0);
    chk("rst_req_value", bus1.rd_data_a, 8'h5A);

    // Normal operation resumes right after reset
    bus0.wr_en = 1; bus0.wr_addr = 2; bus0.wr_data = 8'hC3; bus0.wr_mask = 8'hF0;
    bus0.rd_addr_a = 2;
    tick();
    bus0.wr_en = 0;
    #1 chk("resume", bus0.rd_data_a, 8'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, meaning bits per register (>=2).
REQ-002 SHALL provide parameter NUM_REGS, default 4, meaning register count (>=2); ADDR_W = clog2(NUM_REGS).
REQ-003 SHALL provide parameter RESET_VALUE, default 0, meaning value loaded into every register on reset.
REQ-004 SHALL provide parameter BYPASS, default 1, meaning 1 = same-cycle write forwarding to read ports, 0 = none.
REQ-005 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port wr_en  in  1  write request this cycle.
REQ-008 SHALL have port wr_addr  in  ADDR_W  write target register.
REQ-009 SHALL have port wr_data  in  WIDTH  write data.
REQ-010 SHALL have port wr_mask  in  WIDTH  per-bit write enable (1 = bit updated).
REQ-011 SHALL have port step_en  in  1  increment/decrement request.
REQ-012 SHALL have port step_addr  in  ADDR_W  step target register.
REQ-013 SHALL have port step_dir  in  1  0 = +1, 1 = -1.
REQ-014 SHALL have port step_wrap  out  1  registered one-cycle pulse, previous step wrapped.
REQ-015 SHALL have ports rd_addr_a / rd_addr_b  in  ADDR_W  read selects.
REQ-016 SHALL have ports rd_data_a / rd_data_b  out  WIDTH  combinational read data.
REQ-017 SHALL have ports zero_a / neg_a  out  1  rd_data_a == 0 / rd_data_a[WIDTH-1].

Function
REQ-018 SHALL hold NUM_REGS registers of WIDTH bits; a register changes only via reset, write or step.
REQ-019 SHALL on wr_en with valid wr_addr set reg <= (reg & ~wr_mask) | (wr_data & wr_mask) at next edge; wr_mask = 0 leaves reg unchanged.
REQ-020 SHALL on step_en with valid step_addr set reg <= reg + 1 (step_dir=0) or reg - 1 (step_dir=1), modulo 2^WIDTH.
REQ-021 SHALL assert step_wrap for exactly the cycle after a step that went all-ones -> 0 (inc) or 0 -> all-ones (dec); otherwise 0.
REQ-022 SHALL, when wr_en and step_en target the same valid register in one cycle, apply the masked write only; step is dropped and step_wrap stays 0.
REQ-023 SHALL, when wr_en and step_en target different valid registers, apply both in the same cycle.
REQ-024 SHALL ignore write and step requests whose address >= NUM_REGS (no state change, step_wrap 0).
REQ-025 SHALL drive rd_data_x = register[rd_addr_x] combinationally; rd_addr_x >= NUM_REGS returns 0.
REQ-026 SHALL, when BYPASS=1 and a valid write targets rd_addr_x in the same cycle, drive rd_data_x with the merged value of REQ-019; step results are never forwarded.
REQ-027 SHALL, when BYPASS=0, show written/stepped values on read ports one cycle after the request edge.
REQ-028 SHALL derive zero_a and neg_a from the final rd_data_a, including forwarded values.
REQ-029 SHALL allow both read ports to select the same register simultaneously with identical results.

Reset
REQ-030 SHALL, while reset is high at an edge, load all registers with RESET_VALUE[WIDTH-1:0] and clear step_wrap.
REQ-031 SHALL give reset priority over wr_en and step_en in the same cycle; those requests are discarded.
REQ-032 SHALL keep read ports combinational during reset (reflect register contents, forwarding still active when BYPASS=1).
REQ-033 SHALL have no asynchronous behaviour; reset deasserted mid-sequence resumes normal operation on the next edge.

Verification (WIDTH=8, NUM_REGS=4)
REQ-034 SHALL cover: reset, then write r2=0xA5 mask 0xFF; then mask 0x0F data 0x3C -> r2 = 0xAC, zero_a 0, neg_a 1 when rd_addr_a=2.
REQ-035 SHALL cover: r1=0xFF, step inc r1 -> r1=0x00, step_wrap=1 for one cycle, zero_a=1; step dec r1 -> 0xFF, step_wrap=1 again.
REQ-036 SHALL cover: same cycle wr r3=0x10 mask 0xFF and step inc r3 -> r3=0x10, step_wrap 0; different regs r0/r3 -> both updated.
REQ-037 SHALL cover: BYPASS=1, wr r0=0x55 with rd_addr_a=0 same cycle -> rd_data_a=0x55 that cycle; BYPASS=0 -> old value that cycle, 0x55 next.
REQ-038 SHALL cover: reset asserted with wr_en and step_en active -> all regs = RESET_VALUE, step_wrap 0, requests lost.
REQ-039 SHALL cover: NUM_REGS=3, wr_addr=3 and step_addr=3 -> no change; rd_addr_b=3 -> rd_data_b=0.
